// File: rtl/arbitro_pkg.sv
// Shared types for the memory arbiter: FSM states, requester ids and the default timeout.
package arbitro_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } estado_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_DM = 1'b1
    } req_id_t;

    localparam int TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/contador_timeout.sv
// Counts BUSY cycles; alcanzado marks the last cycle the memory is allowed to answer in.
module contador_timeout
    import arbitro_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic clear,
    input  logic enable,
    output logic alcanzado
);

    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] cnt;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !alcanzado) begin
            cnt <= cnt + CW'(1);
        end
    end

    // cnt is 0 in the first BUSY cycle, so TIMEOUT-1 is the TIMEOUT-th BUSY cycle
    assign alcanzado = (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/arbitro_memoria.sv
// Round-robin arbiter sharing one memory port between instruction fetch (IF) and data (DM).
module arbitro_memoria
    import arbitro_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              IF_Req,
    input  logic [ADDR_W-1:0] IF_Addr,
    output logic              IF_Done,
    output logic [DATA_W-1:0] IF_RData,
    input  logic              DM_Req,
    input  logic              DM_We,
    input  logic [ADDR_W-1:0] DM_Addr,
    input  logic [DATA_W-1:0] DM_WData,
    output logic              DM_Done,
    output logic [DATA_W-1:0] DM_RData,
    output logic              Mem_Req,
    output logic              Mem_We,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic [DATA_W-1:0] Mem_WData,
    input  logic              Mem_Ready,
    input  logic [DATA_W-1:0] Mem_RData,
    output logic              Err,
    output logic              Err_Sticky,
    output logic              Busy
);

    estado_t estado;
    req_id_t dueno;
    req_id_t ultimo;
    req_id_t sel;
    logic    alcanzado;
    logic    cnt_clear;
    logic    cnt_enable;

    // On a conflict the requester that did not win last time gets the port
    always_comb begin
        sel = REQ_IF;
        if (DM_Req && (!IF_Req || ultimo == REQ_IF)) begin
            sel = REQ_DM;
        end
    end

    assign cnt_clear  = (estado != BUSY);
    assign cnt_enable = (estado == BUSY);

    contador_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_contador (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .clear     (cnt_clear),
        .enable    (cnt_enable),
        .alcanzado (alcanzado)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            estado     <= IDLE;
            dueno      <= REQ_IF;
            ultimo     <= REQ_DM;
            Mem_Req    <= 1'b0;
            Mem_We     <= 1'b0;
            Mem_Addr   <= '0;
            Mem_WData  <= '0;
            IF_Done    <= 1'b0;
            DM_Done    <= 1'b0;
            IF_RData   <= '0;
            DM_RData   <= '0;
            Err        <= 1'b0;
            Err_Sticky <= 1'b0;
            Busy       <= 1'b0;
        end else begin
            IF_Done <= 1'b0;
            DM_Done <= 1'b0;
            Err     <= 1'b0;
            case (estado)
                IDLE: begin
                    if (IF_Req || DM_Req) begin
                        dueno  <= sel;
                        ultimo <= sel;
                        if (sel == REQ_DM) begin
                            Mem_Addr  <= DM_Addr;
                            Mem_We    <= DM_We;
                            Mem_WData <= DM_WData;
                        end else begin
                            Mem_Addr  <= IF_Addr;
                            Mem_We    <= 1'b0;
                            Mem_WData <= '0;
                        end
                        Mem_Req <= 1'b1;
                        Busy    <= 1'b1;
                        estado  <= BUSY;
                    end
                end
                BUSY: begin
                    // A ready in the last allowed cycle wins over the timeout
                    if (Mem_Ready || alcanzado) begin
                        Mem_Req <= 1'b0;
                        estado  <= RESP;
                        if (dueno == REQ_DM) begin
                            DM_Done <= 1'b1;
                        end else begin
                            IF_Done <= 1'b1;
                        end
                        if (!Mem_Ready) begin
                            Err        <= 1'b1;
                            Err_Sticky <= 1'b1;
                            if (dueno == REQ_DM) begin
                                DM_RData <= '0;
                            end else begin
                                IF_RData <= '0;
                            end
                        end else if (!Mem_We) begin
                            if (dueno == REQ_DM) begin
                                DM_RData <= Mem_RData;
                            end else begin
                                IF_RData <= Mem_RData;
                            end
                        end
                    end
                end
                RESP: begin
                    Busy   <= 1'b0;
                    estado <= IDLE;
                end
                default: begin
                    estado <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_memoria.sv
// Bench for arbitro_memoria: directed scenarios plus randomized traffic against a transaction-level model.
module tb_arbitro_memoria;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic              Clk = 1'b0;
    logic              Rst_n;
    logic              IF_Req;
    logic [ADDR_W-1:0] IF_Addr;
    logic              IF_Done;
    logic [DATA_W-1:0] IF_RData;
    logic              DM_Req;
    logic              DM_We;
    logic [ADDR_W-1:0] DM_Addr;
    logic [DATA_W-1:0] DM_WData;
    logic              DM_Done;
    logic [DATA_W-1:0] DM_RData;
    logic              Mem_Req;
    logic              Mem_We;
    logic [ADDR_W-1:0] Mem_Addr;
    logic [DATA_W-1:0] Mem_WData;
    logic              Mem_Ready;
    logic [DATA_W-1:0] Mem_RData;
    logic              Err;
    logic              Err_Sticky;
    logic              Busy;

    always #5 Clk = ~Clk;

    arbitro_memoria #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .IF_Req     (IF_Req),
        .IF_Addr    (IF_Addr),
        .IF_Done    (IF_Done),
        .IF_RData   (IF_RData),
        .DM_Req     (DM_Req),
        .DM_We      (DM_We),
        .DM_Addr    (DM_Addr),
        .DM_WData   (DM_WData),
        .DM_Done    (DM_Done),
        .DM_RData   (DM_RData),
        .Mem_Req    (Mem_Req),
        .Mem_We     (Mem_We),
        .Mem_Addr   (Mem_Addr),
        .Mem_WData  (Mem_WData),
        .Mem_Ready  (Mem_Ready),
        .Mem_RData  (Mem_RData),
        .Err        (Err),
        .Err_Sticky (Err_Sticky),
        .Busy       (Busy)
    );

    int n_chk  = 0;
    int n_fail = 0;

    function automatic void chk(string nm, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endfunction

    // ---------------- reference model: one transaction at a time ----------------
    int                m_phase;      // 0 waiting for a request, 1 memory access open, 2 answer cycle
    logic              m_last_dm;
    logic              m_owner_dm;
    int                m_elapsed;
    logic              ok;
    logic [DATA_W-1:0] val;
    logic              e_memreq, e_we, e_ifdone, e_dmdone, e_err, e_sticky, e_busy;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata, e_ifr, e_dmr;

    initial begin
        forever begin
            @(posedge Clk);
            if (!Rst_n) begin
                m_phase = 0; m_last_dm = 1'b1; m_owner_dm = 1'b0; m_elapsed = 0;
                e_memreq = 0; e_we = 0; e_ifdone = 0; e_dmdone = 0; e_err = 0;
                e_sticky = 0; e_busy = 0; e_addr = '0; e_wdata = '0; e_ifr = '0; e_dmr = '0;
            end else begin
                e_ifdone = 0; e_dmdone = 0; e_err = 0;
                if (m_phase == 0) begin
                    if (IF_Req || DM_Req) begin
                        m_owner_dm = DM_Req && (!IF_Req || !m_last_dm);
                        m_last_dm  = m_owner_dm;
                        e_addr     = m_owner_dm ? DM_Addr : IF_Addr;
                        e_we       = m_owner_dm && DM_We;
                        e_wdata    = m_owner_dm ? DM_WData : '0;
                        e_memreq   = 1; e_busy = 1; m_elapsed = 1; m_phase = 1;
                    end
                end else if (m_phase == 1) begin
                    if (Mem_Ready || m_elapsed == TIMEOUT) begin
                        ok       = Mem_Ready;
                        e_memreq = 0;
                        m_phase  = 2;
                        if (m_owner_dm) e_dmdone = 1; else e_ifdone = 1;
                        e_err = !ok;
                        if (!ok) e_sticky = 1;
                        val = ok ? Mem_RData : '0;
                        if (!ok || !e_we) begin
                            if (m_owner_dm) e_dmr = val; else e_ifr = val;
                        end
                    end else begin
                        m_elapsed++;
                    end
                end else begin
                    m_phase = 0;
                    e_busy  = 0;
                end
            end
            #1;
            chk("m_mem_req",   Mem_Req,    e_memreq);
            chk("m_mem_we",    Mem_We,     e_we);
            chk("m_mem_addr",  Mem_Addr,   e_addr);
            chk("m_mem_wdata", Mem_WData,  e_wdata);
            chk("m_if_done",   IF_Done,    e_ifdone);
            chk("m_dm_done",   DM_Done,    e_dmdone);
            chk("m_err",       Err,        e_err);
            chk("m_sticky",    Err_Sticky, e_sticky);
            chk("m_busy",      Busy,       e_busy);
            chk("m_if_rdata",  IF_RData,   e_ifr);
            chk("m_dm_rdata",  DM_RData,   e_dmr);
        end
    end

    // ---------------- stimulus ----------------
    int mode    = 0;   // 0 manual, 1 answer after lat cycles, 2 random ready
    int lat     = 0;
    int wc      = 0;
    int p       = 0;
    bit rand_en = 0;

    task automatic mem_step();
        case (mode)
            1: begin
                if (Mem_Req) begin
                    Mem_Ready = (wc == lat);
                    wc++;
                end else begin
                    Mem_Ready = 1'b0;
                    wc = 0;
                end
                Mem_RData = $urandom;
            end
            2: begin
                Mem_Ready = ($urandom_range(0, 99) < p);
                Mem_RData = $urandom;
            end
            default: ;
        endcase
    endtask

    task automatic rand_step();
        if (IF_Done) IF_Req = 1'b0;
        else if (!IF_Req && $urandom_range(0, 3) == 0) begin
            IF_Req = 1'b1; IF_Addr = $urandom;
        end
        if (DM_Done) DM_Req = 1'b0;
        else if (!DM_Req && $urandom_range(0, 3) == 0) begin
            DM_Req = 1'b1; DM_Addr = $urandom; DM_WData = $urandom; DM_We = $urandom_range(0, 1);
        end
    endtask

    task automatic cyc();
        @(negedge Clk);
        mem_step();
        if (rand_en) rand_step();
    endtask

    task automatic wait_done(output int who);
        int n;
        n = 0; who = 2;
        while (n < 60) begin
            cyc();
            n++;
            if (IF_Done || DM_Done) begin
                who = IF_Done ? 0 : 1;
                break;
            end
        end
        if (who == 2) begin
            n_chk++; n_fail++;
            $display("FAIL done_wait: no Done within 60 cycles (t=%0t)", $time);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int who;
    int n;
    logic [DATA_W-1:0] saved;
    int ptab[6] = '{0, 5, 30, 100, 60, 15};

    initial begin
        Rst_n = 0; IF_Req = 0; IF_Addr = '0; DM_Req = 0; DM_We = 0; DM_Addr = '0; DM_WData = '0;
        Mem_Ready = 0; Mem_RData = '0;
        repeat (3) @(negedge Clk);
        chk("rst_mem_req", Mem_Req, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_sticky", Err_Sticky, 0);
        chk("rst_if_rdata", IF_RData, 0);
        chk("rst_mem_addr", Mem_Addr, 0);
        Rst_n = 1;
        cyc();

        // conflict right after reset: IF, DM, IF, DM, then the pending IF
        mode = 1; lat = 0;
        IF_Req = 1; IF_Addr = 'h20; DM_Req = 1; DM_We = 0; DM_Addr = 'h200; DM_WData = '0;
        for (int k = 0; k < 4; k++) begin
            wait_done(who);
            chk("rr_order", who, k % 2);
            if (who == 0) IF_Req = 0; else if (who == 1) DM_Req = 0;
            cyc();
            if (k < 3) begin IF_Req = 1; DM_Req = 1; end
        end
        wait_done(who);
        chk("rr_tail", who, 0);
        IF_Req = 0;
        cyc();

        // single fetch, ready two cycles after Mem_Req rises
        mode = 0; Mem_Ready = 0;
        IF_Req = 1; IF_Addr = 'h10;
        cyc();
        chk("f_mem_req", Mem_Req, 1);
        chk("f_mem_addr", Mem_Addr, 'h10);
        chk("f_mem_we", Mem_We, 0);
        cyc();
        cyc();
        Mem_Ready = 1; Mem_RData = 'h0050_0093;
        cyc();
        chk("f_if_done", IF_Done, 1);
        chk("f_dm_done", DM_Done, 0);
        chk("f_if_rdata", IF_RData, 'h0050_0093);
        chk("f_err", Err, 0);
        chk("f_mem_req_resp", Mem_Req, 0);
        IF_Req = 0; Mem_Ready = 0;
        cyc();
        chk("f_done_pulse", IF_Done, 0);
        chk("f_busy_idle", Busy, 0);
        chk("f_rdata_hold", IF_RData, 'h0050_0093);

        // DM write with inputs changing after the grant
        saved = DM_RData;
        DM_Req = 1; DM_We = 1; DM_Addr = 'h100; DM_WData = 'hDEAD_BEEF;
        cyc();
        DM_Addr = 'h3; DM_WData = 'h5;
        for (int i = 0; i < 4; i++) begin
            chk("w_mem_req", Mem_Req, 1);
            chk("w_mem_we", Mem_We, 1);
            chk("w_mem_addr", Mem_Addr, 'h100);
            chk("w_mem_wdata", Mem_WData, 'hDEAD_BEEF);
            if (i == 3) begin Mem_Ready = 1; Mem_RData = 'h1234_5678; end
            cyc();
        end
        chk("w_dm_done", DM_Done, 1);
        chk("w_dm_rdata", DM_RData, saved);
        chk("w_err", Err, 0);
        DM_Req = 0; Mem_Ready = 0;
        cyc();

        // no ready at all: timeout after TIMEOUT busy cycles
        IF_Req = 1; IF_Addr = 'h40; n = 0;
        cyc();
        while (Mem_Req && n < 40) begin n++; cyc(); end
        chk("t_busy_cycles", n, 16);
        chk("t_if_done", IF_Done, 1);
        chk("t_err", Err, 1);
        chk("t_if_rdata", IF_RData, 0);
        chk("t_sticky", Err_Sticky, 1);
        IF_Req = 0;
        cyc();
        chk("t_err_pulse", Err, 0);
        chk("t_sticky_hold", Err_Sticky, 1);

        // ready exactly in the 16th busy cycle is a success
        IF_Req = 1; IF_Addr = 'h44;
        cyc(); n = 1;
        while (n < 16) begin cyc(); n++; end
        chk("e_mem_req_16", Mem_Req, 1);
        Mem_Ready = 1; Mem_RData = 'hCAFE_0001;
        cyc();
        chk("e_if_done", IF_Done, 1);
        chk("e_err", Err, 0);
        chk("e_if_rdata", IF_RData, 'hCAFE_0001);
        IF_Req = 0; Mem_Ready = 0;
        cyc();

        // reset in the middle of a transaction
        IF_Req = 1; IF_Addr = 'h80;
        cyc(); cyc(); cyc();
        #2 Rst_n = 0;
        #1;
        chk("r_mem_req", Mem_Req, 0);
        chk("r_busy", Busy, 0);
        chk("r_sticky", Err_Sticky, 0);
        chk("r_if_rdata", IF_RData, 0);
        IF_Req = 0;
        repeat (2) begin
            cyc();
            chk("r_no_done", IF_Done, 0);
        end
        Rst_n = 1;
        mode = 1; lat = 1;
        IF_Req = 1; IF_Addr = 'h84;
        wait_done(who);
        chk("r_after_who", who, 0);
        chk("r_after_err", Err, 0);
        IF_Req = 0;
        cyc();

        // randomized traffic with varying memory responsiveness
        mode = 2; rand_en = 1;
        for (int blk = 0; blk < 12; blk++) begin
            p = ptab[blk % 6];
            repeat (200) cyc();
        end
        rand_en = 0;
        repeat (2) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/arbitro_memoria.md
ARBITRO_MEMORIA -- requirements
Module: arbitro_memoria

Interface
REQ-001 Parameters SHALL be (name, default, meaning): ADDR_W, 32, address width; DATA_W, 32, data width; TIMEOUT, 16, max BUSY cycles waiting Mem_Ready (>=2).
REQ-002 Ports SHALL be (name direction width meaning): Clk input 1 clock; Rst_n input 1 asynchronous active-low reset.
REQ-003 IF_Req input 1 fetch request (level, held until IF_Done); IF_Addr input ADDR_W fetch address.
REQ-004 IF_Done output 1 fetch complete pulse; IF_RData output DATA_W fetched word.
REQ-005 DM_Req input 1 data request (level, held until DM_Done); DM_We input 1 write enable; DM_Addr input ADDR_W; DM_WData input DATA_W.
REQ-006 DM_Done output 1 data complete pulse; DM_RData output DATA_W load data.
REQ-007 Mem_Req output 1; Mem_We output 1; Mem_Addr output ADDR_W; Mem_WData output DATA_W; Mem_Ready input 1; Mem_RData input DATA_W (single shared memory port).
REQ-008 Err output 1 pulse with Done on timeout; Err_Sticky output 1 latched timeout flag; Busy output 1 high in BUSY or RESP.
REQ-009 Clock and reset SHALL be exactly: one clock Clk; reset Rst_n asynchronous, active-low.

Function
REQ-010 FSM states SHALL be IDLE, BUSY, RESP; one transaction in flight at most.
REQ-011 IDLE: no Req -> stay; one Req -> grant it; both -> grant requester not granted last (round-robin); last-grant resets to DM so IF wins first conflict.
REQ-012 On grant (IDLE->BUSY edge) Addr, We (0 for IF), WData SHALL be latched; Mem_* driven from latches only, stable throughout BUSY.
REQ-013 Mem_Req SHALL be high exactly while in BUSY; low in IDLE and RESP.
REQ-014 BUSY: Mem_Ready sampled high -> RESP, capture Mem_RData into the granted requester's RData register (writes capture nothing).
REQ-015 BUSY timeout: cycle counter starts 0 on entry; if TIMEOUT cycles elapse without Mem_Ready -> RESP with Err=1, RData=0, Err_Sticky set.
REQ-016 Mem_Ready on the same cycle the counter reaches TIMEOUT SHALL count as success (no Err).
REQ-017 RESP lasts exactly one cycle: granted Done=1 (other Done=0), Err per REQ-015, then -> IDLE; Req inputs ignored in RESP.
REQ-018 Latency: grant seen at IDLE cycle N, Mem_Req from N+1; Mem_Ready at cycle M -> Done at M+1; minimum request-to-Done 3 cycles.
REQ-019 Requesters SHALL drop Req in the cycle after Done; an IF_Req still high in IDLE is a new request.
REQ-020 RData registers SHALL hold value until next completion for that requester; Mem_Ready outside BUSY ignored.
REQ-021 Err_Sticky SHALL clear only on reset.

Reset
REQ-022 Rst_n low SHALL asynchronously force: state IDLE, Mem_Req 0, Mem_We 0, Mem_Addr 0, Mem_WData 0, IF_Done 0, DM_Done 0, IF_RData 0, DM_RData 0, Err 0, Err_Sticky 0, Busy 0, counter 0, last-grant DM.
REQ-023 Reset mid-transaction SHALL drop it with no Done; first IDLE cycle after release arbitrates normally.

Structure
REQ-024 Shared package arbitro_pkg SHALL hold state enum (IDLE/BUSY/RESP), requester-id typedef (REQ_IF/REQ_DM), default TIMEOUT constant.
REQ-025 Timeout counter SHALL be sub-module contador_timeout (clear, enable, TIMEOUT-reached output).

Verification
REQ-026 IF_Req only, Addr 0x0000_0010, Mem_Ready 2 cycles after Mem_Req, RData 0x0050_0093 -> IF_Done 1 cycle, IF_RData 0x0050_0093, Err 0.
REQ-027 IF_Req and DM_Req same cycle -> IF served first, then DM; repeated conflict alternates DM, IF.
REQ-028 DM write Addr 0x100, WData 0xDEAD_BEEF -> Mem_We 1, Mem_Addr 0x100, Mem_WData 0xDEAD_BEEF stable until Mem_Ready; DM_Done; DM_RData unchanged.
REQ-029 Mem_Ready never asserted, TIMEOUT 16 -> Mem_Req high 16 cycles, then Done with Err 1, RData 0, Err_Sticky 1 until reset.
REQ-030 Rst_n low mid-BUSY -> Mem_Req 0 immediately, no Done; after release new IF_Req served normally.
REQ-031 Mem_Ready in 16th BUSY cycle -> success, Err 0.
